// File: rtl/alu_pkg.sv
// Shared definitions for the multi-word ALU blocks.
// Provides the slice width W and the sequencer state encoding.
package alu_pkg;

    // Width of the shared adder slice; the slice hardware is fixed at 32 bits.
    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder32.sv
// adder32: combinational 32-bit adder slice with carry in/out.
// Ports: a, b (addends), Cin (carry in) -> sum, Cout (carry out).
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        Cin,
    output logic [31:0] sum,
    output logic        Cout
);

    logic [32:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {32'd0, Cin};
    assign sum    = w_full[31:0];
    assign Cout   = w_full[32];

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: NWORDS x W multi-precision add/subtract, one slice per cycle.
// Ports: clk, rst (sync, active-high); req_valid/req_ready with op, a, b,
//        cin in; res_valid/res_ready with sum, cout out; busy = not IDLE.
module mp_add_seq
    import alu_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int W      = alu_pkg::W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                op,
    input  logic [NWORDS*W-1:0] a,
    input  logic [NWORDS*W-1:0] b,
    input  logic                cin,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NWORDS*W-1:0] sum,
    output logic                cout,
    output logic                busy
);

    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_t                     r_state;
    logic [KW-1:0]              r_k;
    logic [NWORDS-1:0][W-1:0]   r_a;
    logic [NWORDS-1:0][W-1:0]   r_b;
    logic [NWORDS-1:0][W-1:0]   r_sum;
    logic                       r_op;
    logic                       r_carry;
    logic                       r_cout;
    logic                       r_req_ready;
    logic                       r_res_valid;
    logic                       r_busy;

    logic [W-1:0]               w_a_word;
    logic [W-1:0]               w_b_word;
    logic [W-1:0]               w_slice_sum;
    logic                       w_slice_cout;

    // Subtraction is a + ~b + carry, where the carry starts as ~borrow_in.
    assign w_a_word = r_a[r_k];
    assign w_b_word = r_op ? ~r_b[r_k] : r_b[r_k];

    adder32 u_slice (
        .a    (w_a_word),
        .b    (w_b_word),
        .Cin  (r_carry),
        .sum  (w_slice_sum),
        .Cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_op        <= 1'b0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_op        <= op;
                        r_carry     <= op ? ~cin : cin;
                        r_k         <= '0;
                        r_state     <= RUN;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[r_k] <= w_slice_sum;
                    r_carry    <= w_slice_cout;
                    if (r_k == K_LAST) begin
                        // Index parks on the last word; acceptance clears it.
                        r_cout      <= w_slice_cout;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + K_ONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_mp_add_seq.sv
// Testbench for mp_add_seq: directed vector table, backpressure, reset
// and ignored-request sequences, then random ops against a 129-bit model.
module tb_mp_add_seq;

    localparam int NW = 4;
    localparam int N  = NW * 32;

    typedef struct {
        logic         op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         c;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.NWORDS(NW), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    function automatic logic [N-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N-1:0] rnd_operand();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return '1;
        if (r == 1) return '0;
        if (r == 2) return {{(N-32){1'b0}}, 32'hFFFFFFFF};
        return rnd_word();
    endfunction

    // Reference: exact difference/sum in N+1 bits; for subtract cout=1
    // means a >= b + borrow_in.
    function automatic void ref_op(input logic o, input logic [N-1:0] x,
                                   input logic [N-1:0] y, input logic c,
                                   output logic [N-1:0] s, output logic co);
        logic [N:0] t;
        if (!o) t = {1'b0, x} + {1'b0, y} + (N+1)'(c);
        else    t = {1'b0, x} - {1'b0, y} - (N+1)'(c);
        s  = t[N-1:0];
        co = o ? ~t[N] : t[N];
    endfunction

    // Latency counts rising edges from the acceptance edge (inclusive)
    // until res_valid is seen high.
    task automatic do_op(input string nm, input logic o,
                         input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic ic, input logic [N-1:0] es,
                         input logic ec, input bit noise);
        int lat;
        int wt;
        wt = 0;
        while (!req_ready && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_ready: req_ready=%b want 1", nm, req_ready);
        end
        op        = o;
        a         = ia;
        b         = ib;
        cin       = ic;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a   = rnd_word();
        b   = rnd_word();
        op  = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        lat = 1;
        while (!res_valid && lat < 40) begin
            if (noise) begin
                req_valid = 1'($urandom_range(0, 1));
                a  = rnd_word();
                b  = rnd_word();
                op = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        checks++;
        if (sum !== es || cout !== ec || lat != NW + 1) begin
            failures++;
            $display("FAIL %s: sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=%0d",
                     nm, sum, cout, lat, es, ec, NW + 1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    vec_t         vecs[12];
    logic [N-1:0] ones;
    logic [N-1:0] xv;
    logic [N-1:0] held_s;
    logic         held_c;
    logic [N-1:0] es;
    logic         ec;
    logic         ro;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    bit           seen;

    initial begin
        ones = '1;
        xv   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        vecs[0]  = '{1'b0, ones, 128'd1, 1'b0, 128'd0, 1'b1};
        vecs[1]  = '{1'b1, 128'd0, 128'd1, 1'b0, ones, 1'b0};
        vecs[2]  = '{1'b1, 128'd5, 128'd3, 1'b1, 128'd1, 1'b1};
        vecs[3]  = '{1'b0, 128'd7, 128'd8, 1'b1, 128'd16, 1'b0};
        vecs[4]  = '{1'b0, 128'd0, 128'd0, 1'b1, 128'd1, 1'b0};
        vecs[5]  = '{1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF,
                     128'd1, 1'b0,
                     128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0};
        vecs[6]  = '{1'b1, xv, xv, 1'b0, 128'd0, 1'b1};
        vecs[7]  = '{1'b1, xv, xv, 1'b1, ones, 1'b0};
        vecs[8]  = '{1'b0, ones, ones, 1'b1, ones, 1'b1};
        vecs[9]  = '{1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                     128'd1, 1'b0,
                     128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[10] = '{1'b0, 128'h0000_0001_0000_0000_0000_0000_0000_0000,
                     128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0,
                     128'h0000_0002_0000_0000_0000_0000_0000_0000, 1'b0};
        vecs[11] = '{1'b1, 128'd3, 128'd5, 1'b0,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                     req_ready, res_valid, busy, sum, cout);
        end
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].cin, vecs[i].s, vecs[i].c, 1'b0);
        end

        // Backpressure: hold the result 10 cycles, poke requests meanwhile.
        op        = 1'b0;
        a         = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
        b         = 128'd1;
        cin       = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(posedge clk); #1;
        end
        held_s = 128'h0000_0000_FFFF_FFFF_0000_0001_0000_0000;
        held_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (sum !== held_s || cout !== held_c || req_ready !== 1'b0 ||
                busy !== 1'b1 || res_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold%0d: sum=%h cout=%b rdy=%b busy=%b vld=%b want sum=%h cout=%b 0 1 1",
                         i, sum, cout, req_ready, busy, res_valid, held_s, held_c);
            end
            req_valid = 1'($urandom_range(0, 1));
            a         = rnd_word();
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL release: rdy=%b busy=%b vld=%b want 1 0 0",
                     req_ready, busy, res_valid);
        end

        // Reset during the second RUN cycle aborts the operation.
        op        = 1'b0;
        a         = ones;
        b         = 128'd1;
        cin       = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
            sum !== '0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL rst_run: rdy=%b busy=%b vld=%b sum=%h cout=%b want 1 0 0 0 0",
                     req_ready, busy, res_valid, sum, cout);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_stale: res_valid=1 want 0");
        end
        do_op("after_rst", 1'b0, 128'd7, 128'd8, 1'b1, 128'd16, 1'b0, 1'b0);

        // Reset wins over a simultaneous request.
        op        = 1'b1;
        a         = 128'd9;
        b         = 128'd2;
        req_valid = 1'b1;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_prio: busy=%b rdy=%b want 0 1", busy, req_ready);
        end

        // Random ops against the model; odd ops also spray requests while busy.
        for (int i = 0; i < 10000; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = rnd_operand();
            rb = rnd_operand();
            rc = 1'($urandom_range(0, 1));
            ref_op(ro, ra, rb, rc, es, ec);
            do_op($sformatf("rnd%0d", i), ro, ra, rb, rc, es, ec, 1'(i & 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4, meaning number of 32-bit words per operand (legal range 2..16).
REQ-002 SHALL have parameter W, default 32, meaning word width of the shared adder slice (fixed at 32).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, meaning an operation request is presented.
REQ-006 SHALL have port req_ready, output, 1, meaning the block can accept a request this cycle.
REQ-007 SHALL have port op, input, 1, meaning 0 = add, 1 = subtract.
REQ-008 SHALL have port a, input, NWORDS*W, meaning first operand, unsigned.
REQ-009 SHALL have port b, input, NWORDS*W, meaning second operand, unsigned.
REQ-010 SHALL have port cin, input, 1, meaning carry-in for add and borrow-in for subtract.
REQ-011 SHALL have port res_valid, output, 1, meaning sum and cout are valid.
REQ-012 SHALL have port res_ready, input, 1, meaning the consumer accepts the result.
REQ-013 SHALL have port sum, output, NWORDS*W, meaning the result.
REQ-014 SHALL have port cout, output, 1, meaning final carry-out; for subtract it is 1 when no borrow occurred.
REQ-015 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-016 SHALL be an FSM with three states: IDLE, RUN and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1.
REQ-018 On acceptance, the block SHALL latch a, b, op and cin, clear the word index to 0, and go IDLE->RUN.
REQ-019 The latched carry SHALL be set to cin for add and to ~cin for subtract.
REQ-020 Each RUN cycle SHALL perform exactly one word-slice add on word k, taking the a word, the b word (inverted if op=1), and the latched carry.
REQ-021 In each RUN cycle, the slice result SHALL be stored into sum word k, the slice carry-out SHALL be latched, and k SHALL be incremented.
REQ-022 After word NWORDS-1, the FSM SHALL go RUN->DONE, with cout equal to the final carry; res_valid SHALL be 1 in DONE.
REQ-023 Latency SHALL be fixed: res_valid asserts NWORDS+1 cycles after the acceptance edge, independent of data.
REQ-024 In DONE, sum and cout SHALL hold stable until res_ready=1; that cycle the FSM goes DONE->IDLE.
REQ-025 A request cannot be accepted in the same cycle as result release; req_ready rises the cycle after.
REQ-026 req_valid asserted while busy SHALL be ignored, with no latching and no effect on the operation in progress.
REQ-027 Changes on a, b, op or cin after acceptance SHALL NOT affect the result.
REQ-028 Arithmetic SHALL wrap modulo 2^(NWORDS*W); overflow is reported only via cout.
REQ-029 The word index SHALL be ceil(log2(NWORDS)) bits wide and SHALL never exceed NWORDS-1.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and set req_ready=1, res_valid=0, busy=0, sum=0, cout=0 and the index to 0.
REQ-031 rst during RUN or DONE SHALL abort the operation; no res_valid pulse SHALL follow.
REQ-032 rst SHALL take priority over req_valid and res_ready in the same cycle.

Structure
REQ-033 The state enum (IDLE/RUN/DONE) and the constant W=32 SHALL live in the shared package alu_pkg.
REQ-034 The word slice SHALL be one instance of the existing combinational adder32 (ports a, b, Cin, sum, Cout); no other arithmetic is inferred.

Verification
REQ-035 Add test: a=2^128-1, b=1, cin=0, op=0 -> sum=0, cout=1, with res_valid exactly 5 cycles after acceptance.
REQ-036 Subtract test: a=0, b=1, cin=0, op=1 -> sum=2^128-1, cout=0 (borrow); then a=5, b=3, cin=1 -> sum=1, cout=1.
REQ-037 Backpressure test: hold res_ready=0 for 10 cycles in DONE -> sum and cout stable, req_ready=0 and busy=1 throughout.
REQ-038 Reset test: assert rst in RUN cycle 2, then issue a=7, b=8, cin=1 -> no stale res_valid; result sum=16, cout=0.
REQ-039 Ignored-request and random test: req_valid toggling while busy is ignored; 10000 random add/sub ops match a 129-bit reference model.
